// File: rtl/lab4_pkg.sv
// Shared types and constants for the lab4 stimulus and Mealy stages.
package lab4_pkg;

    localparam int PAT_CNT_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/serial_pattern_gen_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;
    logic         w_at_max;

    assign w_at_max = (r_count == {W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !w_at_max) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/serial_pattern_gen.sv
// Serialises a loaded bit pattern onto the Mealy stage input, optionally
// repeating it back-to-back, and counts completed patterns.
module serial_pattern_gen
    import lab4_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int LEN_W     = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [WIDTH-1:0]     data,
    input  logic [LEN_W-1:0]     len,
    input  logic                 rpt,
    input  logic                 stop,
    output logic                 ready,
    output logic                 bit_out,
    output logic                 bit_valid,
    output logic [LEN_W-1:0]     bit_idx,
    output logic                 last,
    output logic [PAT_CNT_W-1:0] pat_cnt
);

    // Position within the pattern maps to a data bit; MSB-first counts down from len-1.
    function automatic logic pick_bit(input logic [WIDTH-1:0] d,
                                      input logic [LEN_W-1:0] l,
                                      input logic [LEN_W-1:0] idx);
        logic [LEN_W-1:0] pos;
        logic [WIDTH-1:0] sh;
        pos = (MSB_FIRST != 0) ? (l - idx - LEN_W'(1)) : idx;
        sh  = d >> pos;
        return sh[0];
    endfunction

    state_t           r_state;
    logic [WIDTH-1:0] r_data;
    logic [LEN_W-1:0] r_len;
    logic             r_rpt;
    logic             r_stop;
    logic             r_bit_out;
    logic             r_bit_valid;
    logic [LEN_W-1:0] r_bit_idx;
    logic             r_last;
    logic             r_ready;

    state_t           w_state_next;
    logic [WIDTH-1:0] w_data_next;
    logic [LEN_W-1:0] w_len_next;
    logic             w_rpt_next;
    logic             w_stop_next;
    logic             w_bit_out_next;
    logic             w_bit_valid_next;
    logic [LEN_W-1:0] w_bit_idx_next;
    logic             w_last_next;
    logic             w_ready_next;
    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic [LEN_W-1:0] w_len_eff;
    logic [LEN_W-1:0] w_idx_inc;
    logic             w_continue;

    assign w_len_eff  = ((len == '0) || (len > LEN_W'(WIDTH))) ? LEN_W'(WIDTH) : len;
    assign w_idx_inc  = r_bit_idx + LEN_W'(1);
    // A stop on the final bit's edge still cancels the wrap-around.
    assign w_continue = r_rpt && !r_stop && !stop;

    always_comb begin
        w_state_next     = r_state;
        w_data_next      = r_data;
        w_len_next       = r_len;
        w_rpt_next       = r_rpt;
        w_stop_next      = r_stop;
        w_bit_out_next   = 1'b0;
        w_bit_valid_next = 1'b0;
        w_bit_idx_next   = '0;
        w_last_next      = 1'b0;
        w_ready_next     = 1'b1;
        w_cnt_clr        = 1'b0;
        w_cnt_inc        = 1'b0;

        case (r_state)
            IDLE: begin
                if (load) begin
                    w_data_next      = data;
                    w_len_next       = w_len_eff;
                    w_rpt_next       = rpt;
                    w_stop_next      = 1'b0;
                    w_cnt_clr        = 1'b1;
                    w_state_next     = SHIFT;
                    w_bit_out_next   = pick_bit(data, w_len_eff, '0);
                    w_bit_valid_next = 1'b1;
                    w_last_next      = (w_len_eff == LEN_W'(1));
                    w_ready_next     = 1'b0;
                end
            end

            SHIFT: begin
                if (stop) begin
                    w_stop_next = 1'b1;
                    w_rpt_next  = 1'b0;
                end
                if (r_last) begin
                    w_cnt_inc = 1'b1;
                    if (w_continue) begin
                        w_bit_out_next   = pick_bit(r_data, r_len, '0);
                        w_bit_valid_next = 1'b1;
                        w_last_next      = (r_len == LEN_W'(1));
                        w_ready_next     = 1'b0;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else begin
                    w_bit_idx_next   = w_idx_inc;
                    w_bit_out_next   = pick_bit(r_data, r_len, w_idx_inc);
                    w_bit_valid_next = 1'b1;
                    w_last_next      = (w_idx_inc == (r_len - LEN_W'(1)));
                    w_ready_next     = 1'b0;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_data      <= '0;
            r_len       <= '0;
            r_rpt       <= 1'b0;
            r_stop      <= 1'b0;
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
            r_bit_idx   <= '0;
            r_last      <= 1'b0;
            r_ready     <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_data      <= w_data_next;
            r_len       <= w_len_next;
            r_rpt       <= w_rpt_next;
            r_stop      <= w_stop_next;
            r_bit_out   <= w_bit_out_next;
            r_bit_valid <= w_bit_valid_next;
            r_bit_idx   <= w_bit_idx_next;
            r_last      <= w_last_next;
            r_ready     <= w_ready_next;
        end
    end

    sat_counter #(
        .W (PAT_CNT_W)
    ) u_pat_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_cnt_clr),
        .i_inc   (w_cnt_inc),
        .o_count (pat_cnt)
    );

    assign ready     = r_ready;
    assign bit_out   = r_bit_out;
    assign bit_valid = r_bit_valid;
    assign bit_idx   = r_bit_idx;
    assign last      = r_last;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Directed bench for serial_pattern_gen, with a small Mealy stand-in on bit_out.
module tb_serial_pattern_gen;
    import lab4_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load;
    logic [7:0] data;
    logic [3:0] len;
    logic       rpt;
    logic       stop;
    logic       ready;
    logic       bit_out;
    logic       bit_valid;
    logic [3:0] bit_idx;
    logic       last;
    logic [7:0] pat_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_pattern_gen #(
        .WIDTH     (8),
        .MSB_FIRST (1),
        .LEN_W     (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .data      (data),
        .len       (len),
        .rpt       (rpt),
        .stop      (stop),
        .ready     (ready),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .bit_idx   (bit_idx),
        .last      (last),
        .pat_cnt   (pat_cnt)
    );

    // Stand-in for the downstream Mealy machine: S0=0, S1=1, S2=2.
    logic [1:0] m_state;
    logic [1:0] m_next;
    logic       m_out;

    always_comb begin
        m_next = 2'd0;
        m_out  = 1'b0;
        case (m_state)
            2'd0: if (bit_out) begin m_next = 2'd2; m_out = 1'b1; end
            2'd1: if (bit_out) begin m_next = 2'd2; m_out = 1'b0; end
                  else         begin m_next = 2'd0; m_out = 1'b1; end
            2'd2: if (bit_out) begin m_next = 2'd1; m_out = 1'b0; end
            default: begin m_next = 2'd0; m_out = 1'b0; end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_state <= 2'd0;
        else        m_state <= m_next;
    end

    task step;
        @(posedge clk);
        #1;
    endtask

    task do_load(input logic [7:0] d, input logic [3:0] l, input logic r);
        data = d;
        len  = l;
        rpt  = r;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task test_reset;
        rst_n = 1'b0; load = 1'b0; stop = 1'b0; rpt = 1'b0; data = '0; len = '0;
        #7;
        checks++;
        if ({ready, bit_out, bit_valid, last} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags got %b want 1000", {ready, bit_out, bit_valid, last});
        end
        checks++;
        if ({bit_idx, pat_cnt} !== 12'h000) begin
            errors++;
            $display("FAIL reset_idx_cnt got %h want 000", {bit_idx, pat_cnt});
        end
        #1 rst_n = 1'b1;
        step();
    endtask

    task test_basic;
        logic [7:0] seq;
        logic [7:0] got, want;
        seq = 8'b1011_0010;
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL basic_pre_ready got %b want 1", ready); end
        do_load(8'hB2, 4'd8, 1'b0);
        for (int k = 0; k < 8; k++) begin
            got  = {bit_out, bit_valid, last, ready, bit_idx};
            want = {seq[7-k], 1'b1, (k == 7), 1'b0, 4'(k)};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL basic_cycle%0d got %b want %b", k, got, want);
            end
            step();
        end
        got  = {bit_out, bit_valid, last, ready, bit_idx};
        checks++;
        if (got !== 8'b0001_0000) begin errors++; $display("FAIL basic_idle got %b want 00010000", got); end
        checks++;
        if (pat_cnt !== 8'd1) begin errors++; $display("FAIL basic_pat_cnt got %0d want 1", pat_cnt); end
    endtask

    task test_length;
        logic [7:0] c_data [3];
        logic [3:0] c_len  [3];
        logic [7:0] c_seq  [3];
        int         c_n    [3];
        logic [7:0] got, want;
        logic [7:0] s;
        c_data[0] = 8'hFD; c_len[0] = 4'd3;  c_seq[0] = 8'b0000_0101; c_n[0] = 3;
        c_data[1] = 8'hFD; c_len[1] = 4'd0;  c_seq[1] = 8'b1111_1101; c_n[1] = 8;
        c_data[2] = 8'h81; c_len[2] = 4'd12; c_seq[2] = 8'b1000_0001; c_n[2] = 8;
        for (int t = 0; t < 3; t++) begin
            s = c_seq[t];
            do_load(c_data[t], c_len[t], 1'b0);
            for (int k = 0; k < c_n[t]; k++) begin
                got  = {bit_out, bit_valid, last, ready, bit_idx};
                want = {s[c_n[t]-1-k], 1'b1, (k == c_n[t] - 1), 1'b0, 4'(k)};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL len_case%0d_cycle%0d got %b want %b", t, k, got, want);
                end
                step();
            end
            got = {bit_out, bit_valid, last, ready, bit_idx};
            checks++;
            if (got !== 8'b0001_0000) begin
                errors++;
                $display("FAIL len_case%0d_idle got %b want 00010000", t, got);
            end
        end
    endtask

    task test_repeat_stop;
        logic [3:0] seq;
        logic [7:0] got, want;
        seq = 4'b0101;
        do_load(8'hA5, 4'd4, 1'b1);
        for (int c = 0; c < 8; c++) begin
            got  = {bit_out, bit_valid, last, ready, bit_idx};
            want = {seq[3-(c%4)], 1'b1, ((c % 4) == 3), 1'b0, 4'(c % 4)};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL rpt_cycle%0d got %b want %b", c, got, want);
            end
            checks++;
            if (pat_cnt !== 8'(c / 4)) begin
                errors++;
                $display("FAIL rpt_cnt_cycle%0d got %0d want %0d", c, pat_cnt, c / 4);
            end
            stop = (c == 5);
            step();
        end
        stop = 1'b0;
        got = {bit_out, bit_valid, last, ready, bit_idx};
        checks++;
        if (got !== 8'b0001_0000) begin errors++; $display("FAIL rpt_stop_idle got %b want 00010000", got); end
        checks++;
        if (pat_cnt !== 8'd2) begin errors++; $display("FAIL rpt_stop_cnt got %0d want 2", pat_cnt); end
    endtask

    task test_load_ignored;
        logic [7:0] seq;
        logic [3:0] seq2;
        logic [7:0] got, want;
        int         waited;
        seq  = 8'b1011_0010;
        seq2 = 4'b0101;
        do_load(8'hB2, 4'd8, 1'b0);
        for (int c = 0; c < 8; c++) begin
            got  = {bit_out, bit_valid, last, ready, bit_idx};
            want = {seq[7-c], 1'b1, (c == 7), 1'b0, 4'(c)};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL ldign_cycle%0d got %b want %b", c, got, want);
            end
            if (c == 2) begin load = 1'b1; data = 8'h0F; len = 4'd3; rpt = 1'b1; end
            if (c == 4) load = 1'b0;
            step();
        end
        got = {bit_out, bit_valid, last, ready, bit_idx};
        checks++;
        if (got !== 8'b0001_0000) begin errors++; $display("FAIL ldign_idle got %b want 00010000", got); end
        // stop held high across idle cycles must not leak into the next load
        stop = 1'b1;
        step();
        step();
        stop = 1'b0;
        do_load(8'hA5, 4'd4, 1'b1);
        for (int c = 0; c < 10; c++) begin
            got  = {bit_out, bit_valid, last, ready, bit_idx};
            want = {seq2[3-(c%4)], 1'b1, ((c % 4) == 3), 1'b0, 4'(c % 4)};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL idlestop_cycle%0d got %b want %b", c, got, want);
            end
            stop = (c == 9);
            step();
        end
        stop = 1'b0;
        waited = 0;
        while (ready !== 1'b1 && waited < 10) begin
            step();
            waited++;
        end
        checks++;
        if (waited != 2) begin errors++; $display("FAIL idlestop_end_cycles got %0d want 2", waited); end
        checks++;
        if (pat_cnt !== 8'd3) begin errors++; $display("FAIL idlestop_cnt got %0d want 3", pat_cnt); end
    endtask

    task test_len1_saturate;
        logic [7:0] got;
        logic [7:0] want_cnt;
        do_load(8'h01, 4'd1, 1'b1);
        for (int c = 0; c < 260; c++) begin
            got = {bit_out, bit_valid, last, ready, bit_idx};
            checks++;
            if (got !== 8'b1110_0000) begin
                errors++;
                $display("FAIL len1_cycle%0d got %b want 11100000", c, got);
            end
            want_cnt = (c > 255) ? 8'd255 : 8'(c);
            checks++;
            if (pat_cnt !== want_cnt) begin
                errors++;
                $display("FAIL len1_cnt_cycle%0d got %0d want %0d", c, pat_cnt, want_cnt);
            end
            stop = (c == 259);
            step();
        end
        stop = 1'b0;
        got = {bit_out, bit_valid, last, ready, bit_idx};
        checks++;
        if (got !== 8'b0001_0000) begin errors++; $display("FAIL len1_idle got %b want 00010000", got); end
        checks++;
        if (pat_cnt !== 8'd255) begin errors++; $display("FAIL len1_sat got %0d want 255", pat_cnt); end
    endtask

    task test_mealy;
        logic [1:0] st_exp [5];
        logic [3:0] out_seq;
        st_exp[0] = 2'd0; st_exp[1] = 2'd2; st_exp[2] = 2'd1; st_exp[3] = 2'd0; st_exp[4] = 2'd2;
        out_seq = 4'b1011;
        step();
        do_load(8'h0D, 4'd4, 1'b0);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if ({m_state, m_out} !== {st_exp[c], out_seq[3-c]}) begin
                errors++;
                $display("FAIL mealy_cycle%0d state/out got %0d/%b want %0d/%b",
                         c, m_state, m_out, st_exp[c], out_seq[3-c]);
            end
            step();
        end
        checks++;
        if (m_state !== st_exp[4]) begin errors++; $display("FAIL mealy_final got %0d want %0d", m_state, st_exp[4]); end
    endtask

    task test_async_reset;
        logic [7:0] got, want;
        logic [3:0] seq;
        seq = 4'b0101;
        do_load(8'hB2, 4'd8, 1'b1);
        repeat (11) step();
        checks++;
        if ({bit_idx, bit_out, pat_cnt} !== {4'd3, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL areset_pre got idx %0d bit %b cnt %0d want idx 3 bit 1 cnt 1", bit_idx, bit_out, pat_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        got = {bit_out, bit_valid, last, ready, bit_idx};
        checks++;
        if (got !== 8'b0001_0000) begin errors++; $display("FAIL areset_outputs got %b want 00010000", got); end
        checks++;
        if (pat_cnt !== 8'd0) begin errors++; $display("FAIL areset_cnt got %0d want 0", pat_cnt); end
        #2 rst_n = 1'b1;
        step();
        do_load(8'hA5, 4'd4, 1'b0);
        for (int c = 0; c < 4; c++) begin
            got  = {bit_out, bit_valid, last, ready, bit_idx};
            want = {seq[3-c], 1'b1, (c == 3), 1'b0, 4'(c)};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL areset_reload_cycle%0d got %b want %b", c, got, want);
            end
            step();
        end
        checks++;
        if ({ready, pat_cnt} !== {1'b1, 8'd1}) begin
            errors++;
            $display("FAIL areset_reload_end got ready %b cnt %0d want ready 1 cnt 1", ready, pat_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_length();
        test_repeat_stop();
        test_load_ignored();
        test_len1_saturate();
        test_mealy();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
